// File: rtl/queue_ctl.sv
// W-bit, N-entry FIFO with valid/ready on both sides, zero-latency output,
// live occupancy count, registered almost-full/almost-empty flags and a synchronous flush.
module queue_ctl #(
   parameter  int unsigned W  = 1,
   parameter  int unsigned N  = 2,
   parameter  int unsigned AF = N,
   parameter  int unsigned AE = 0,
   localparam int unsigned CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_en,
   input  logic          flush,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic [W-1:0]  i,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [W-1:0]  o,
   output logic [CW-1:0] count,
   output logic          almost_full,
   output logic          almost_empty
);

   // Elaboration-time parameter sanity checks
   if (W == 0) begin : g_bad_w
      $error("queue_ctl: W must be >= 1");
   end
   if (N == 0) begin : g_bad_n
      $error("queue_ctl: N must be >= 1");
   end
   if (AF == 0 || AF > N) begin : g_bad_af
      $error("queue_ctl: AF must satisfy 1 <= AF <= N");
   end
   if (AE >= N) begin : g_bad_ae
      $error("queue_ctl: AE must satisfy 0 <= AE <= N-1");
   end

   logic          enq;
   logic          deq;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          o_valid_q, o_valid_d;
   logic          af_q, af_d;
   logic          ae_q, ae_d;

   // Full queue still accepts when the consumer drains in the same cycle
   assign i_ready = !flush && (!full_q || o_ready);
   assign enq     = clk_en && i_valid && i_ready;
   assign deq     = clk_en && o_valid_q && o_ready;

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (enq && !deq) begin
         count_d = count_q + CW'(1);
      end else if (deq && !enq) begin
         count_d = count_q - CW'(1);
      end
      full_d    = (count_d == CW'(N));
      o_valid_d = (count_d != '0);
      af_d      = (count_d >= CW'(AF));
      ae_d      = (count_d <= CW'(AE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         full_q    <= 1'b0;
         o_valid_q <= 1'b0;
         af_q      <= 1'b0;
         ae_q      <= 1'b1;
      end else if (clk_en) begin
         count_q   <= count_d;
         full_q    <= full_d;
         o_valid_q <= o_valid_d;
         af_q      <= af_d;
         ae_q      <= ae_d;
      end
   end

   assign o_valid      = o_valid_q;
   assign count        = count_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;

   if (N == 1) begin : g_single
      logic [W-1:0] data_q;

      // Storage is never reset; o_valid qualifies its contents
      always_ff @(posedge clk) begin
         if (enq) begin
            data_q <= i;
         end
      end

      assign o = data_q;
   end else begin : g_ring
      localparam int unsigned AW = $clog2(N);

      logic [W-1:0]  mem_q [N];
      logic [AW-1:0] rd_q, rd_d;
      logic [AW-1:0] wr_q, wr_d;

      // Pointers wrap on an explicit compare so any depth works
      always_comb begin
         rd_d = rd_q;
         wr_d = wr_q;
         if (flush) begin
            rd_d = '0;
            wr_d = '0;
         end else begin
            if (enq) begin
               wr_d = (wr_q == AW'(N - 1)) ? '0 : wr_q + AW'(1);
            end
            if (deq) begin
               rd_d = (rd_q == AW'(N - 1)) ? '0 : rd_q + AW'(1);
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_q <= '0;
            wr_q <= '0;
         end else if (clk_en) begin
            rd_q <= rd_d;
            wr_q <= wr_d;
         end
      end

      always_ff @(posedge clk) begin
         if (enq) begin
            mem_q[wr_q] <= i;
         end
      end

      assign o = mem_q[rd_q];
   end

endmodule

// File: tb/tb_queue_ctl.sv
// Self-checking bench for queue_ctl: directed scenarios on an N=3 build plus random
// traffic on N=3, N=1 and N=4 builds, all checked every cycle against queue models.
module tb_queue_ctl;

   localparam int NA = 3;
   localparam int NB = 1;
   localparam int NC = 4;

   logic       clk;
   logic       rst;
   logic       clk_en;
   logic       flush;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] din;

   logic       ir_a, ov_a, af_a, ae_a;
   logic [7:0] o_a;
   logic [1:0] cnt_a;
   logic       ir_b, ov_b, af_b, ae_b;
   logic [7:0] o_b;
   logic [0:0] cnt_b;
   logic       ir_c, ov_c, af_c, ae_c;
   logic [7:0] o_c;
   logic [2:0] cnt_c;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] qc[$];

   queue_ctl #(.W(8), .N(NA), .AF(2), .AE(1)) u_dut_a (
      .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
      .i_valid(i_valid), .i_ready(ir_a), .i(din),
      .o_valid(ov_a), .o_ready(o_ready), .o(o_a),
      .count(cnt_a), .almost_full(af_a), .almost_empty(ae_a)
   );

   queue_ctl #(.W(8), .N(NB), .AF(1), .AE(0)) u_dut_b (
      .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
      .i_valid(i_valid), .i_ready(ir_b), .i(din),
      .o_valid(ov_b), .o_ready(o_ready), .o(o_b),
      .count(cnt_b), .almost_full(af_b), .almost_empty(ae_b)
   );

   queue_ctl #(.W(8), .N(NC), .AF(3), .AE(1)) u_dut_c (
      .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
      .i_valid(i_valid), .i_ready(ir_c), .i(din),
      .o_valid(ov_c), .o_ready(o_ready), .o(o_c),
      .count(cnt_c), .almost_full(af_c), .almost_empty(ae_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one instance against its model queue: size, head and handshake rules
   task automatic chk_inst(input string nm, input int n, input int af, input int ae,
                           input int sz, input logic [7:0] hd, input logic ov, input int cnt,
                           input logic afl, input logic ael, input logic ir, input logic [7:0] ob);
      chk({nm, ".o_valid"}, int'(ov), int'(sz != 0));
      chk({nm, ".count"}, cnt, sz);
      chk({nm, ".almost_full"}, int'(afl), int'(sz >= af));
      chk({nm, ".almost_empty"}, int'(ael), int'(sz <= ae));
      chk({nm, ".i_ready"}, int'(ir), int'(!flush && (sz < n || o_ready)));
      if (sz != 0) chk({nm, ".o"}, int'(ob), int'(hd));
   endtask

   // Reference models: plain FIFO queues updated from the handshake rules
   always @(posedge clk or posedge rst) begin
      if (rst) qa.delete();
      else if (clk_en) begin
         if (flush) qa.delete();
         else if (i_valid && (qa.size() < NA || o_ready)) begin
            if (qa.size() != 0 && o_ready) void'(qa.pop_front());
            qa.push_back(din);
         end else if (qa.size() != 0 && o_ready) void'(qa.pop_front());
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) qb.delete();
      else if (clk_en) begin
         if (flush) qb.delete();
         else if (i_valid && (qb.size() < NB || o_ready)) begin
            if (qb.size() != 0 && o_ready) void'(qb.pop_front());
            qb.push_back(din);
         end else if (qb.size() != 0 && o_ready) void'(qb.pop_front());
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) qc.delete();
      else if (clk_en) begin
         if (flush) qc.delete();
         else if (i_valid && (qc.size() < NC || o_ready)) begin
            if (qc.size() != 0 && o_ready) void'(qc.pop_front());
            qc.push_back(din);
         end else if (qc.size() != 0 && o_ready) void'(qc.pop_front());
      end
   end

   always @(negedge clk) begin
      chk_inst("a", NA, 2, 1, qa.size(), (qa.size() != 0) ? qa[0] : 8'h00,
               ov_a, int'(cnt_a), af_a, ae_a, ir_a, o_a);
      chk_inst("b", NB, 1, 0, qb.size(), (qb.size() != 0) ? qb[0] : 8'h00,
               ov_b, int'(cnt_b), af_b, ae_b, ir_b, o_b);
      chk_inst("c", NC, 3, 1, qc.size(), (qc.size() != 0) ? qc[0] : 8'h00,
               ov_c, int'(cnt_c), af_c, ae_c, ir_c, o_c);
   end

   initial begin
      int pv;
      int pr;
      rst = 1'b1; clk_en = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; din = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.count", int'(cnt_a), 0);
      chk("rst.o_valid", int'(ov_a), 0);
      chk("rst.almost_full", int'(af_a), 0);
      chk("rst.almost_empty", int'(ae_a), 1);
      chk("rst.i_ready", int'(ir_a), 1);
      rst = 1'b0;

      // Fill and drain with A, B, C
      i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din = 8'(8'hA + k);
         tick();
         chk("fill.count", int'(cnt_a), k + 1);
         chk("fill.almost_full", int'(af_a), int'(k >= 1));
         chk("fill.almost_empty", int'(ae_a), int'(k == 0));
      end
      #1;
      chk("fill.i_ready_full", int'(ir_a), 0);
      i_valid = 1'b0;
      o_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("drain.o", int'(o_a), 8'hA + k);
         tick();
      end
      chk("drain.count", int'(cnt_a), 0);
      chk("drain.o_valid", int'(ov_a), 0);
      chk("drain.almost_empty", int'(ae_a), 1);

      // Further rounds walk both pointers through the wrap
      for (int r = 0; r < 5; r++) begin
         o_ready = 1'b0;
         i_valid = 1'b1;
         for (int k = 0; k < 3; k++) begin
            din = 8'(r * 16 + k);
            tick();
         end
         i_valid = 1'b0;
         o_ready = 1'b1;
         for (int k = 0; k < 3; k++) begin
            #1;
            chk("wrap.o", int'(o_a), r * 16 + k);
            tick();
         end
      end

      // Full pass-through at count 3
      o_ready = 1'b0;
      i_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         din = 8'(8'h11 * k);
         tick();
      end
      o_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         din = 8'(k + 1);
         #1;
         chk("pass.i_ready", int'(ir_a), 1);
         chk("pass.o", int'(o_a), (k < 3) ? 8'h11 * (k + 1) : k - 2);
         tick();
         chk("pass.count", int'(cnt_a), 3);
      end
      i_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("pass.tail_o", int'(o_a), k + 4);
         tick();
      end

      // Zero latency from empty
      o_ready = 1'b0;
      i_valid = 1'b1;
      din = 8'h05;
      tick();
      i_valid = 1'b0;
      chk("zlat.o_valid", int'(ov_a), 1);
      chk("zlat.o", int'(o_a), 5);
      chk("zlat.count", int'(cnt_a), 1);

      // Flush at count 2 with both handshakes offered
      i_valid = 1'b1;
      din = 8'h06;
      tick();
      chk("flush.pre_count", int'(cnt_a), 2);
      flush = 1'b1; o_ready = 1'b1; din = 8'h77;
      #1;
      chk("flush.i_ready", int'(ir_a), 0);
      tick();
      flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
      chk("flush.count", int'(cnt_a), 0);
      chk("flush.o_valid", int'(ov_a), 0);
      chk("flush.almost_empty", int'(ae_a), 1);
      chk("flush.almost_full", int'(af_a), 0);
      i_valid = 1'b1;
      din = 8'h09;
      tick();
      chk("flush.next_o", int'(o_a), 9);
      chk("flush.next_o_valid", int'(ov_a), 1);

      // clk_en low freezes state, even with flush asserted
      din = 8'h3C;
      tick();
      clk_en = 1'b0; i_valid = 1'b1; o_ready = 1'b1; din = 8'hEE;
      for (int k = 0; k < 4; k++) begin
         flush = (k == 2);
         #1;
         if (k == 2) chk("cken.i_ready_flush", int'(ir_a), 0);
         tick();
         chk("cken.count", int'(cnt_a), 2);
         chk("cken.o", int'(o_a), 9);
      end
      clk_en = 1'b1; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      chk("arst.o_valid", int'(ov_a), 0);
      chk("arst.count", int'(cnt_a), 0);
      chk("arst.almost_empty", int'(ae_a), 1);
      rst = 1'b0;

      // Random traffic, biases re-drawn every 500 cycles
      pv = 5;
      pr = 5;
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) begin
            pv = $urandom_range(1, 9);
            pr = $urandom_range(1, 9);
         end
         tick();
         clk_en  = ($urandom_range(0, 9) != 0);
         flush   = ($urandom_range(0, 59) == 0);
         i_valid = ($urandom_range(0, 9) < pv);
         o_ready = ($urandom_range(0, 9) < pr);
         din     = 8'($urandom);
         if ($urandom_range(0, 1999) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            rst = 1'b0;
         end
      end
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
